// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared timing constants and types for the VGA raster path.
//            Holds the 640x480@60 default porch/sync widths, the derived
//            totals and sync window bounds, and the {hs, vs, act} bundle
//            that travels through the alignment delay line.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W = 10;

    // Default 640x480@60 timing (pixel clocks / lines)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Derived values for the default timing; sync windows are [START, END)
    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    typedef struct packed {
        logic hs;   // active low
        logic vs;   // active low
        logic act;  // visible area
    } sync_bundle_t;

    // Inactive bundle: syncs deasserted, outside the visible area
    localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay_line
// Purpose  : Parameterised-depth shift register with a per-bit reset value.
//            DEPTH = 0 degenerates to a plain wire.
// Ports    : clk     - clock
//            rst_n   - asynchronous reset, active low
//            i_data  - WIDTH-bit input
//            o_data  - i_data delayed by DEPTH clocks
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        assign o_data = i_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
            end else begin
                r_stage[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_data = r_stage[DEPTH-1];
    end

endmodule : sync_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster counters, sync generation and DAC output stage.
//            X/Y counters feed the pixel generator; its RGB (PIPE_DELAY
//            clocks later) is gated to black outside the visible area and
//            registered together with HS/VS/BLANK_N so all leave aligned.
// Ports    : iVGA_CLK      - pixel clock
//            iRST_N        - asynchronous reset, active low
//            iRed/Green/Blue - generator RGB for the X/Y of PIPE_DELAY ago
//            oVGA_X/oVGA_Y - raw counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//            oFrame_Tick   - one-clock pulse at start of vertical blank
//            oVGA_HS/VS    - active-low syncs, pipeline-aligned
//            oVGA_BLANK_N  - high in visible area, pipeline-aligned
//            oVGA_R/G/B    - gated RGB to DAC
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int PIPE_DELAY = 1           // 0..4
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_N,
    input  logic [9:0]       iRed,
    input  logic [9:0]       iGreen,
    input  logic [9:0]       iBlue,
    output logic [CNT_W-1:0] oVGA_X,
    output logic [CNT_W-1:0] oVGA_Y,
    output logic             oFrame_Tick,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_BLANK_N,
    output logic [9:0]       oVGA_R,
    output logic [9:0]       oVGA_G,
    output logic [9:0]       oVGA_B
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] c_h_last    = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last    = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_vis     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] c_v_vis     = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] c_hs_start  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] c_hs_end    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] c_vs_start  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] c_vs_end    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_frame_tick;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic [9:0]       r_red;
    logic [9:0]       r_green;
    logic [9:0]       r_blue;

    logic             w_h_wrap;
    logic             w_v_wrap;
    sync_bundle_t     w_raw;
    sync_bundle_t     w_dly;

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_v_wrap = (r_v_cnt == c_v_last);

    // ------------------------------------------------------------------
    // Raster counters: v advances only on the h wrap clock
    // ------------------------------------------------------------------
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Tick lands on the clock after the first blank line's first pixel
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (r_h_cnt == '0) && (r_v_cnt == c_v_vis);
        end
    end

    // ------------------------------------------------------------------
    // Raw timing decoded from the current counter values
    // ------------------------------------------------------------------
    always_comb begin
        w_raw     = SYNC_IDLE;
        w_raw.hs  = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
        w_raw.vs  = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
        w_raw.act = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    end

    // Match the pixel generator's latency so sync/act line up with RGB
    sync_delay_line #(
        .WIDTH     ($bits(sync_bundle_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk    (iVGA_CLK),
        .rst_n  (iRST_N),
        .i_data (w_raw),
        .o_data (w_dly)
    );

    // ------------------------------------------------------------------
    // Output register: syncs and gated RGB leave on the same clock
    // ------------------------------------------------------------------
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else begin
            r_hs      <= w_dly.hs;
            r_vs      <= w_dly.vs;
            r_blank_n <= w_dly.act;
            r_red     <= w_dly.act ? iRed   : '0;
            r_green   <= w_dly.act ? iGreen : '0;
            r_blue    <= w_dly.act ? iBlue  : '0;
        end
    end

    assign oVGA_X       = r_h_cnt;
    assign oVGA_Y       = r_v_cnt;
    assign oFrame_Tick  = r_frame_tick;
    assign oVGA_HS      = r_hs;
    assign oVGA_VS      = r_vs;
    assign oVGA_BLANK_N = r_blank_n;
    assign oVGA_R       = r_red;
    assign oVGA_G       = r_green;
    assign oVGA_B       = r_blue;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench. Instance A uses default 640x480 timing
//            with PIPE_DELAY=1 and constant full-scale RGB; instance B uses
//            a reduced 15x12 raster with PIPE_DELAY=2 and a generator model
//            returning R=X, G=Y (2 clocks late), B=3FF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Reduced raster for instance B: H 8/2/3/2 = 15, V 6/2/2/2 = 12
    localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VV = 6, B_VF = 2, B_VS = 2, B_VB = 2;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

    localparam logic [32:0] IDLE = {1'b1, 1'b1, 1'b0, 30'd0};

    typedef struct {
        int          due;
        logic [32:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [9:0] a_x, a_y, a_r, a_g, a_b;
    logic       a_tick, a_hs, a_vs, a_bn;
    logic [9:0] b_x, b_y, b_r, b_g, b_b;
    logic       b_tick, b_hs, b_vs, b_bn;
    logic [9:0] b_gr1, b_gr2, b_gg1, b_gg2;
    logic [9:0] a_rgb_in = 10'h3FF;
    logic [9:0] b_blue_in = 10'h3FF;

    logic [32:0] a_out, b_out;
    assign a_out = {a_hs, a_vs, a_bn, a_r, a_g, a_b};
    assign b_out = {b_hs, b_vs, b_bn, b_r, b_g, b_b};

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vga_timing_gen #(.PIPE_DELAY(1)) dut_a (
        .iVGA_CLK(clk), .iRST_N(rst_a),
        .iRed(a_rgb_in), .iGreen(a_rgb_in), .iBlue(a_rgb_in),
        .oVGA_X(a_x), .oVGA_Y(a_y), .oFrame_Tick(a_tick),
        .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK_N(a_bn),
        .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .PIPE_DELAY(2)
    ) dut_b (
        .iVGA_CLK(clk), .iRST_N(rst_b),
        .iRed(b_gr2), .iGreen(b_gg2), .iBlue(b_blue_in),
        .oVGA_X(b_x), .oVGA_Y(b_y), .oFrame_Tick(b_tick),
        .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_N(b_bn),
        .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b)
    );

    // Pixel generator model for B: two-clock latency from X/Y to RGB
    always @(posedge clk) begin
        b_gr1 <= b_x;  b_gr2 <= b_gr1;
        b_gg1 <= b_y;  b_gg2 <= b_gg1;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [32:0] pix(input int x, input int y,
                                        input int hv, input int hf, input int hs,
                                        input int vv, input int vf, input int vs,
                                        input logic [9:0] r, input logic [9:0] g,
                                        input logic [9:0] b);
        logic act, h, v;
        act = (x < hv) && (y < vv);
        h   = !((x >= hv + hf) && (x < hv + hf + hs));
        v   = !((y >= vv + vf) && (y < vv + vf + vs));
        return {h, v, act, act ? r : 10'd0, act ? g : 10'd0, act ? b : 10'd0};
    endfunction

    // ---------------- stimulus-side reference models ----------------
    initial begin : model_a
        int ax, ay;
        ax = 0; ay = 0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                ax = 0; ay = 0;
                check("A_rst_xy_tick", {a_x, a_y, a_tick}, 21'd0);
            end else begin
                check("A_xy", {a_x, a_y}, {10'(ax), 10'(ay)});
                check("A_tick", a_tick, (ax == 1 && ay == 480));
                qa.push_back('{cyc + 2, pix(ax, ay, 640, 16, 96, 480, 10, 2,
                                            10'h3FF, 10'h3FF, 10'h3FF)});
                ax++;
                if (ax == 800) begin
                    ax = 0; ay++;
                    if (ay == 525) ay = 0;
                end
            end
        end
    end

    initial begin : model_b
        int bx, by;
        bx = 0; by = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                bx = 0; by = 0;
                check("B_rst_xy_tick", {b_x, b_y, b_tick}, 21'd0);
            end else begin
                check("B_xy", {b_x, b_y}, {10'(bx), 10'(by)});
                check("B_tick", b_tick, (bx == 1 && by == B_VV));
                qb.push_back('{cyc + 3, pix(bx, by, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS,
                                            10'(bx), 10'(by), 10'h3FF)});
                bx++;
                if (bx == B_HT) begin
                    bx = 0; by++;
                    if (by == B_VT) by = 0;
                end
            end
        end
    end

    // ---------------- output monitors ----------------
    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                qa.delete();
                check("A_rst_out", a_out, IDLE);
            end else if (qa.size() > 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                check("A_out", a_out, e.val);
            end else begin
                check("A_out_idle", a_out, IDLE);
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                qb.delete();
                check("B_rst_out", b_out, IDLE);
            end else if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                check("B_out", b_out, e.val);
            end else begin
                check("B_out_idle", b_out, IDLE);
            end
        end
    end

    // ---------------- directed timing checks ----------------
    initial begin : main
        int t, w, c0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // A: HS first low at X=658, 96 wide, 800-clock period
        t = 0;
        @(negedge clk);
        while (a_hs !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        check("A_hs_found", (t < 2000), 1);
        check("A_hs_first_x", a_x, 658);
        c0 = cyc;
        w = 0;
        while (a_hs === 1'b0 && w < 2000) begin @(negedge clk); w++; end
        check("A_hs_width", w, 96);
        t = 0;
        while (a_hs !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        check("A_line_period", cyc - c0, 800);
        check("A_hs_second_xy", {a_x, a_y}, {10'd658, 10'd1});

        // B: tick spacing and width, VS width
        t = 0;
        while (b_tick !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("B_tick_found", (t < 1000), 1);
        c0 = cyc;
        @(negedge clk);
        check("B_tick_width", b_tick, 0);
        t = 0;
        while (b_tick !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("B_tick_period", cyc - c0, B_HT * B_VT);
        t = 0;
        while (b_vs !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
        w = 0;
        while (b_vs === 1'b0 && w < 1000) begin @(negedge clk); w++; end
        check("B_vs_width", w, B_HT * B_VS);

        // B: asynchronous reset mid-frame at (5,3)
        t = 0;
        while (!(b_x == 10'd5 && b_y == 10'd3) && t < 1000) begin @(negedge clk); t++; end
        check("B_midframe_found", (t < 1000), 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("B_async_rst", {b_out, b_x, b_y, b_tick}, {IDLE, 20'd0, 1'b0});
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b1;
        // Counters read (0,0) on the first sample; tick shows at (1,V_VISIBLE)
        t = 0;
        @(negedge clk);
        while (b_tick !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("B_first_tick", t, B_HT * B_VV + 1);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
